simplez_rx: RTL and testbench

Serial receiver peripheral for the Simplez SoC: the receiving end of the 8N1 asynchronous serial link that the CPU drives on `tx`. It oversamples an incoming line, validates start and stop bits, and presents each received byte in a holding register with a ready flag. It also reports framing and overrun errors. The flags are cleared by a one-cycle read strobe from the CPU's I/O decode logic.

---
 rtl/simplez_rx.sv | 141 ++++++++++++++
 tb/tb_simplez_rx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/simplez_rx.sv
// Simplez SoC serial receiver: 8N1 oversampling receiver with a byte holding
// register and sticky ready, framing-error and overrun flags.
module simplez_rx #(
    parameter int BAUD = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rcv_clr,
    output logic [7:0] data,
    output logic       rcv,
    output logic       ferr,
    output logic       ovr
);

    localparam int DIV_W = (BAUD > 1) ? $clog2(BAUD) : 1;
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BAUD / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_FULL = DIV_W'(BAUD - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bitn_q, bitn_d;
    logic [7:0]       sr_q, sr_d;
    logic [7:0]       data_q, data_d;
    logic             rcv_q, rcv_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;

    logic             rx_s;
    logic             sample;

    assign rx_s   = sync_q[1];
    assign sample = (div_q == '0);

    always_comb begin
        state_d = state_q;
        sync_d  = {sync_q[0], rx};
        div_d   = div_q;
        bitn_d  = bitn_q;
        sr_d    = sr_q;
        data_d  = data_q;
        rcv_d   = rcv_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;

        // A read strobe clears the flags; a completing frame below overrides it.
        if (rcv_clr) begin
            rcv_d  = 1'b0;
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    div_d   = DIV_HALF;
                end
            end
            START: begin
                if (sample) begin
                    if (!rx_s) begin
                        state_d = DATA;
                        div_d   = DIV_FULL;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    div_d = div_q - DIV_ONE;
                end
            end
            DATA: begin
                if (sample) begin
                    sr_d   = {rx_s, sr_q[7:1]};
                    bitn_d = bitn_q + 3'd1;
                    div_d  = DIV_FULL;
                    if (bitn_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    div_d = div_q - DIV_ONE;
                end
            end
            STOP: begin
                // Re-arm at mid stop bit so a back-to-back start bit is caught.
                if (sample) begin
                    state_d = IDLE;
                    if (rx_s) begin
                        data_d = sr_q;
                        rcv_d  = 1'b1;
                        ovr_d  = rcv_q & ~rcv_clr;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    div_d = div_q - DIV_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            div_q   <= '0;
            bitn_q  <= 3'd0;
            sr_q    <= 8'h00;
            data_q  <= 8'h00;
            rcv_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            div_q   <= div_d;
            bitn_q  <= bitn_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            rcv_q   <= rcv_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data = data_q;
    assign rcv  = rcv_q;
    assign ferr = ferr_q;
    assign ovr  = ovr_q;

endmodule

// File: tb/tb_simplez_rx.sv
// Scoreboard bench for simplez_rx: stimulus pushes the expected output state,
// a monitor pops and compares whenever the registered outputs change.
module tb_simplez_rx;

    localparam int BAUD = 8;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       rcv_clr;
    logic [7:0] data;
    logic       rcv;
    logic       ferr;
    logic       ovr;

    simplez_rx #(.BAUD(BAUD)) dut (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .rcv_clr (rcv_clr),
        .data    (data),
        .rcv     (rcv),
        .ferr    (ferr),
        .ovr     (ovr)
    );

    typedef struct {
        logic [7:0] d;
        logic       r;
        logic       f;
        logic       o;
        int         cyc;
        int         id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   next_id = 0;
    bit   mon_en = 0;
    logic [10:0] prev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // cyc_exp < 0 means the edge on which the change lands is not checked.
    task automatic push_exp(input logic [7:0] d, input logic r, input logic f,
                            input logic o, input int cyc_exp);
        exp_t e;
        e.d = d; e.r = r; e.f = f; e.o = o; e.cyc = cyc_exp; e.id = next_id;
        next_id = next_id + 1;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            logic [10:0] cur;
            exp_t e;
            cur = {data, rcv, ferr, ovr};
            if (cur !== prev) begin
                checks = checks + 1;
                if (sb.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL unexpected_change: got data=%02h rcv=%b ferr=%b ovr=%b at cyc %0d, required no change",
                             data, rcv, ferr, ovr, cyc);
                end else begin
                    e = sb.pop_front();
                    if (data !== e.d || rcv !== e.r || ferr !== e.f || ovr !== e.o ||
                        (e.cyc >= 0 && cyc != e.cyc)) begin
                        errors = errors + 1;
                        $display("FAIL event%0d: got data=%02h rcv=%b ferr=%b ovr=%b cyc=%0d, required data=%02h rcv=%b ferr=%b ovr=%b cyc=%0d",
                                 e.id, data, rcv, ferr, ovr, cyc, e.d, e.r, e.f, e.o, e.cyc);
                    end
                end
                prev = cur;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BAUD) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BAUD) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic pulse_clr();
        rcv_clr = 1'b1;
        @(negedge clk);
        rcv_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        rx      = 1'b1;
        rcv_clr = 1'b0;
        repeat (3) @(negedge clk);

        checks = checks + 1;
        if ({data, rcv, ferr, ovr} !== 11'h000) begin
            errors = errors + 1;
            $display("FAIL reset_state: got data=%02h rcv=%b ferr=%b ovr=%b, required 00 0 0 0",
                     data, rcv, ferr, ovr);
        end
        rst  = 1'b0;
        prev = 11'h000;
        mon_en = 1'b1;
        idle(4);

        // Single byte, latency t0+78 (t0 = next posedge after this negedge).
        push_exp(8'hA5, 1, 0, 0, cyc + 79);
        send_byte(8'hA5, 1'b1);
        idle(2);
        push_exp(8'hA5, 0, 0, 0, cyc + 1);
        pulse_clr();
        idle(4);

        // Back-to-back frames with a read strobe during the second one.
        push_exp(8'h00, 1, 0, 0, cyc + 79);
        push_exp(8'h00, 0, 0, 0, cyc + 85);
        push_exp(8'hFF, 1, 0, 0, cyc + 159);
        fork
            begin
                send_byte(8'h00, 1'b1);
                send_byte(8'hFF, 1'b1);
            end
            begin
                idle(84);
                pulse_clr();
            end
        join
        idle(2);
        push_exp(8'hFF, 0, 0, 0, -1);
        pulse_clr();
        idle(4);

        // Framing error keeps data, then a good byte leaves ferr sticky.
        push_exp(8'hFF, 0, 1, 0, cyc + 79);
        send_byte(8'h3C, 1'b0);
        idle(2 * BAUD);
        push_exp(8'h11, 1, 1, 0, cyc + 79);
        send_byte(8'h11, 1'b1);
        idle(2);
        push_exp(8'h11, 0, 0, 0, -1);
        pulse_clr();
        idle(4);

        // Overrun.
        push_exp(8'h12, 1, 0, 0, cyc + 79);
        send_byte(8'h12, 1'b1);
        idle(3);
        push_exp(8'h34, 1, 0, 1, cyc + 79);
        send_byte(8'h34, 1'b1);
        idle(2);
        push_exp(8'h34, 0, 0, 0, -1);
        pulse_clr();
        idle(4);

        // Glitch shorter than half a bit: no output change expected.
        rx = 1'b0;
        idle(2);
        rx = 1'b1;
        idle(3 * BAUD);
        push_exp(8'h5A, 1, 0, 0, cyc + 79);
        send_byte(8'h5A, 1'b1);
        idle(4);

        // Read strobe on a good-stop completion edge: completion wins, no overrun.
        push_exp(8'h7E, 1, 0, 0, cyc + 79);
        fork
            send_byte(8'h7E, 1'b1);
            begin
                idle(78);
                pulse_clr();
            end
        join
        idle(4);

        // Read strobe on a bad-stop completion edge: ferr set, rcv cleared.
        push_exp(8'h7E, 0, 1, 0, cyc + 79);
        fork
            send_byte(8'h99, 1'b0);
            begin
                idle(78);
                pulse_clr();
            end
        join
        idle(2 * BAUD);
        push_exp(8'h7E, 0, 0, 0, -1);
        pulse_clr();
        idle(4);

        // Reset in the middle of bit 3.
        push_exp(8'h66, 1, 0, 0, cyc + 79);
        send_byte(8'h66, 1'b1);
        idle(4);
        rx = 1'b0;
        idle(4 * BAUD + BAUD / 2);
        push_exp(8'h00, 0, 0, 0, -1);
        #1;
        rst = 1'b1;
        rx  = 1'b1;
        #1;
        checks = checks + 1;
        if ({data, rcv, ferr, ovr} !== 11'h000) begin
            errors = errors + 1;
            $display("FAIL async_reset: got data=%02h rcv=%b ferr=%b ovr=%b, required 00 0 0 0",
                     data, rcv, ferr, ovr);
        end
        idle(3);
        rst = 1'b0;
        idle(2 * BAUD);
        push_exp(8'hC3, 1, 0, 0, cyc + 79);
        send_byte(8'hC3, 1'b1);
        idle(2 * BAUD);

        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain: got %0d pending events, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
